// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
//   mode_e    : display mode encodings, as driven on the mode input
//   SEG_BLANK : all-segments-off pattern
package seg_pkg;

  localparam int unsigned SEG_W = 7;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_SCROLL = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_BLANK  = 2'b11
  } mode_e;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0;

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timebase: per-slot counter, digit index and end-of-frame pulse.
//   clk, rst     : clock, synchronous active-high reset
//   scan_cnt     : registered count within the current digit slot (0..SCAN_DIV-1)
//   digit_idx    : registered index of the digit being scanned (0..DIGITS-1)
//   frame_end_c  : combinational, high on the last cycle of a frame
//   frame_done   : registered one-cycle pulse on the cycle after frame_end_c
module seg_scan_timer #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 10_000,
  localparam int unsigned CNT_W   = $clog2(SCAN_DIV),
  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] scan_cnt,
  output logic [IDX_W-1:0] digit_idx,
  output logic             frame_end_c,
  output logic             frame_done
);

  logic tick_c;

  // Tick marks the last cycle of a digit slot; the last tick of a frame also ends the frame.
  always_comb begin
    tick_c      = (scan_cnt == CNT_W'(SCAN_DIV - 1));
    frame_end_c = tick_c && (digit_idx == IDX_W'(DIGITS - 1));
  end

  // Counter, index and frame pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt   <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end_c;
      if (tick_c) begin
        scan_cnt <= '0;
        if (digit_idx == IDX_W'(DIGITS - 1)) digit_idx <= '0;
        else                                 digit_idx <= digit_idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment display driver with scroll, blink, blank and PWM dimming.
//   clk, rst         : clock, synchronous active-high reset
//   wr_en/addr/seg   : pattern buffer write port, usable at any time
//   mode             : 00 static, 01 scroll, 10 blink, 11 blank (taken at frame boundaries)
//   brightness       : duty level 0..7, 7 = full on
//   seg              : registered segment drive
//   digit_select     : registered one-hot digit enable
//   frame_done       : one-cycle pulse after each completed frame
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned SCAN_DIV   = 10_000,
  parameter int unsigned BUF_DEPTH  = 16,
  parameter int unsigned SCROLL_DIV = 50
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(BUF_DEPTH)-1:0] wr_addr,
  input  logic [6:0]                   wr_seg,
  input  logic [1:0]                   mode,
  input  logic [2:0]                   brightness,
  output logic [6:0]                   seg,
  output logic [DIGITS-1:0]            digit_select,
  output logic                         frame_done
);

  localparam int unsigned ADDR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FC_W   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [CNT_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]  digit_idx;
  logic              frame_end_c;

  mode_e             mode_q;
  logic [FC_W-1:0]   frame_cnt;
  logic [ADDR_W-1:0] offset;
  logic              phase_off;

  logic [SEG_W-1:0]  seg_buf [BUF_DEPTH];

  logic [31:0]       lit_lim_c;
  logic              show_c;
  logic [ADDR_W-1:0] rd_addr_c;

  seg_scan_timer #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .scan_cnt    (scan_cnt),
    .digit_idx   (digit_idx),
    .frame_end_c (frame_end_c),
    .frame_done  (frame_done)
  );

  // Mode register plus frame-rate scroll offset and blink phase; all change only at frame ends.
  // Any mode change restarts the frame count, so scroll begins at offset 0 and blink begins lit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_STATIC;
      frame_cnt <= '0;
      offset    <= '0;
      phase_off <= 1'b0;
    end else if (frame_end_c) begin
      if (mode_e'(mode) != mode_q) begin
        mode_q    <= mode_e'(mode);
        frame_cnt <= '0;
        offset    <= '0;
        phase_off <= 1'b0;
      end else if (mode_q == MODE_SCROLL || mode_q == MODE_BLINK) begin
        if (frame_cnt == FC_W'(SCROLL_DIV - 1)) begin
          frame_cnt <= '0;
          if (mode_q == MODE_SCROLL) offset    <= offset + ADDR_W'(1);
          else                       phase_off <= ~phase_off;
        end else begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end
    end
  end

  // Pattern buffer; reads see the pre-write contents in the write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) seg_buf[i] <= SEG_BLANK;
    end else if (wr_en) begin
      seg_buf[wr_addr] <= wr_seg;
    end
  end

  // PWM window, blanking conditions and buffer read address (wraps mod BUF_DEPTH).
  always_comb begin
    lit_lim_c = ((32'(brightness) + 32'd1) * 32'(SCAN_DIV)) >> 3;
    show_c    = (32'(scan_cnt) < lit_lim_c)
              && (mode_q != MODE_BLANK)
              && !((mode_q == MODE_BLINK) && phase_off);
    rd_addr_c = offset + ADDR_W'(digit_idx);
  end

  // Registered display drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg          <= SEG_BLANK;
      digit_select <= '0;
    end else if (show_c) begin
      seg          <= seg_buf[rd_addr_c];
      digit_select <= DIGITS'(1) << digit_idx;
    end else begin
      seg          <= SEG_BLANK;
      digit_select <= '0;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with a frame-arithmetic reference model.
module tb_seg_scan_display;

  localparam int DIG   = 4;
  localparam int SD    = 8;
  localparam int BD    = 8;
  localparam int SCR   = 2;
  localparam int FRAME = DIG * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [6:0] wr_seg;
  logic [1:0] mode;
  logic [2:0] brightness;
  logic [6:0] seg;
  logic [3:0] digit_select;
  logic       frame_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: cycles since reset, effective mode, frames spent in that mode, buffer image.
  int         m_t;
  int         m_mode;
  int         m_fim;
  logic [6:0] m_buf [BD];

  logic [6:0] es;
  logic [3:0] ed;
  logic       ef;

  seg_scan_display #(
    .DIGITS(DIG), .SCAN_DIV(SD), .BUF_DEPTH(BD), .SCROLL_DIV(SCR)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_seg(wr_seg),
    .mode(mode), .brightness(brightness), .seg(seg), .digit_select(digit_select),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Advance one clock; returns the outputs the model expects right after this edge.
  task automatic step(output logic [6:0] e_seg, output logic [3:0] e_ds, output logic e_fd);
    int  cnt, idx, off;
    bit  vis;
    if (rst) begin
      e_seg = 7'h0; e_ds = 4'h0; e_fd = 1'b0;
      m_t = 0; m_mode = 0; m_fim = 0;
      for (int i = 0; i < BD; i++) m_buf[i] = 7'h0;
    end else begin
      cnt  = m_t % SD;
      idx  = (m_t / SD) % DIG;
      e_fd = ((m_t % FRAME) == FRAME - 1);
      off  = (m_mode == 1) ? (m_fim / SCR) % BD : 0;
      vis  = (cnt < ((int'(brightness) + 1) * SD) / 8) && (m_mode != 3);
      if (m_mode == 2 && ((m_fim / SCR) % 2) == 1) vis = 1'b0;
      e_seg = vis ? m_buf[(off + idx) % BD] : 7'h0;
      e_ds  = vis ? 4'(1 << idx) : 4'h0;
      if (e_fd) begin
        if (int'(mode) != m_mode) begin m_mode = int'(mode); m_fim = 0; end
        else m_fim++;
      end
      if (wr_en) m_buf[wr_addr] = wr_seg;
      m_t++;
    end
    @(posedge clk);
    #1;
  endtask

  // Step without checking until the model's frame position equals pos.
  task automatic run_to(input int pos);
    logic [6:0] s; logic [3:0] d; logic f;
    for (int k = 0; k < FRAME && (m_t % FRAME) != pos; k++) step(s, d, f);
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_seg = '0; mode = 2'b00; brightness = 3'd7;
    for (int k = 0; k < 3; k++) begin
      step(es, ed, ef);
      n_cmp++;
      if ({seg, digit_select, frame_done} !== 12'h0) begin
        n_err++;
        $display("FAIL reset: got seg=%h ds=%b fd=%b, expected all 0", seg, digit_select, frame_done);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_static;
    logic [6:0] pat [4];
    int last_fd, pulses;
    pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F;
    last_fd = -1; pulses = 0;
    for (int k = 0; k < 4 + 3 * FRAME; k++) begin
      wr_en = (k < 4); wr_addr = 3'(k); wr_seg = (k < 4) ? pat[k % 4] : 7'h0;
      step(es, ed, ef);
      n_cmp++;
      if ({seg, digit_select, frame_done} !== {es, ed, ef}) begin
        n_err++;
        $display("FAIL static t=%0d: got seg=%h ds=%b fd=%b, expected seg=%h ds=%b fd=%b",
                 m_t, seg, digit_select, frame_done, es, ed, ef);
      end
      if (frame_done) begin
        if (last_fd >= 0) begin
          n_cmp++;
          if (k - last_fd != FRAME) begin
            n_err++;
            $display("FAIL frame_period: got %0d cycles, expected %0d", k - last_fd, FRAME);
          end
        end
        last_fd = k; pulses++;
      end
    end
    wr_en = 1'b0;
    n_cmp++;
    if (pulses < 2) begin
      n_err++;
      $display("FAIL frame_done_count: got %0d pulses, expected at least 2", pulses);
    end
  endtask

  task automatic test_brightness;
    int lit;
    brightness = 3'd3;
    run_to(0);
    lit = 0;
    for (int k = 0; k < FRAME; k++) begin
      step(es, ed, ef);
      n_cmp++;
      if ({seg, digit_select, frame_done} !== {es, ed, ef}) begin
        n_err++;
        $display("FAIL brightness t=%0d: got seg=%h ds=%b fd=%b, expected seg=%h ds=%b fd=%b",
                 m_t, seg, digit_select, frame_done, es, ed, ef);
      end
      if (digit_select != 4'h0 && (k % SD) < 4) lit++;
      if (digit_select != 4'h0 && (k % SD) >= 4) lit += 100;
    end
    n_cmp++;
    if (lit != 16) begin
      n_err++;
      $display("FAIL brightness_duty: got lit score %0d, expected 16", lit);
    end
    brightness = 3'd7;
  endtask

  task automatic test_scroll;
    logic [6:0] seq [$];
    for (int i = 0; i < BD; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_seg = 7'(i + 1);
      step(es, ed, ef);
    end
    wr_en = 1'b0;
    run_to(0);
    mode = 2'b01;
    for (int k = 0; k < 20 * FRAME; k++) begin
      step(es, ed, ef);
      n_cmp++;
      if ({seg, digit_select, frame_done} !== {es, ed, ef}) begin
        n_err++;
        $display("FAIL scroll t=%0d: got seg=%h ds=%b fd=%b, expected seg=%h ds=%b fd=%b",
                 m_t, seg, digit_select, frame_done, es, ed, ef);
      end
      if (digit_select == 4'b0001 && (seq.size() == 0 || seq[$] != seg)) seq.push_back(seg);
    end
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (k >= seq.size()) begin
        n_err++;
        $display("FAIL scroll_seq[%0d]: got nothing, expected %0d", k, (k % 8) + 1);
      end else if (seq[k] != 7'((k % 8) + 1)) begin
        n_err++;
        $display("FAIL scroll_seq[%0d]: got %0d, expected %0d", k, seq[k], (k % 8) + 1);
      end
    end
  endtask

  task automatic test_blink;
    int lit [8];
    run_to(0);
    mode = 2'b10;
    for (int k = 0; k < FRAME; k++) step(es, ed, ef);
    for (int f = 0; f < 8; f++) lit[f] = 0;
    for (int k = 0; k < 8 * FRAME; k++) begin
      if (k == 3 * FRAME + 10) mode = 2'b11;
      if (k == 3 * FRAME + 20) mode = 2'b10;
      step(es, ed, ef);
      n_cmp++;
      if ({seg, digit_select, frame_done} !== {es, ed, ef}) begin
        n_err++;
        $display("FAIL blink t=%0d: got seg=%h ds=%b fd=%b, expected seg=%h ds=%b fd=%b",
                 m_t, seg, digit_select, frame_done, es, ed, ef);
      end
      if (digit_select != 4'h0) lit[k / FRAME]++;
    end
    for (int f = 0; f < 8; f++) begin
      n_cmp++;
      if (lit[f] != (((f / 2) % 2 == 0) ? FRAME : 0)) begin
        n_err++;
        $display("FAIL blink_frame[%0d]: got %0d lit cycles, expected %0d",
                 f, lit[f], ((f / 2) % 2 == 0) ? FRAME : 0);
      end
    end
  endtask

  task automatic test_write_hazard;
    mode = 2'b00;
    for (int k = 0; k < 2 * FRAME; k++) step(es, ed, ef);
    run_to(2 * SD + 2);
    wr_en = 1'b1; wr_addr = 3'd2; wr_seg = 7'h7F;
    step(es, ed, ef);
    n_cmp++;
    if ({seg, digit_select, frame_done} !== {es, ed, ef}) begin
      n_err++;
      $display("FAIL write_same_cycle: got seg=%h ds=%b, expected seg=%h ds=%b", seg, digit_select, es, ed);
    end
    wr_en = 1'b0;
    step(es, ed, ef);
    n_cmp++;
    if (seg !== 7'h7F || digit_select !== 4'b0100) begin
      n_err++;
      $display("FAIL write_next_cycle: got seg=%h ds=%b, expected seg=7f ds=0100", seg, digit_select);
    end
  endtask

  task automatic test_reset_mid_frame;
    run_to(2 * SD + 5);
    rst = 1'b1;
    step(es, ed, ef);
    n_cmp++;
    if ({seg, digit_select, frame_done} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_mid: got seg=%h ds=%b fd=%b, expected all 0", seg, digit_select, frame_done);
    end
    rst = 1'b0;
    step(es, ed, ef);
    n_cmp++;
    if (seg !== 7'h0 || digit_select !== 4'b0001 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_restart: got seg=%h ds=%b fd=%b, expected seg=00 ds=0001 fd=0",
               seg, digit_select, frame_done);
    end
    for (int k = 0; k < 2 * FRAME; k++) begin
      step(es, ed, ef);
      n_cmp++;
      if ({seg, digit_select, frame_done} !== {es, ed, ef}) begin
        n_err++;
        $display("FAIL reset_cleared t=%0d: got seg=%h ds=%b fd=%b, expected seg=%h ds=%b fd=%b",
                 m_t, seg, digit_select, frame_done, es, ed, ef);
      end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 4000; k++) begin
      wr_en   = ($urandom_range(0, 9) < 3);
      wr_addr = 3'($urandom_range(0, BD - 1));
      wr_seg  = 7'($urandom);
      if ($urandom_range(0, 49) == 0) brightness = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 999) == 0);
      step(es, ed, ef);
      n_cmp++;
      if ({seg, digit_select, frame_done} !== {es, ed, ef}) begin
        n_err++;
        $display("FAIL random t=%0d: got seg=%h ds=%b fd=%b, expected seg=%h ds=%b fd=%b",
                 m_t, seg, digit_select, frame_done, es, ed, ef);
      end
    end
    rst = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_seg = '0; mode = 2'b00; brightness = 3'd7;
    m_t = 0; m_mode = 0; m_fim = 0;
    for (int i = 0; i < BD; i++) m_buf[i] = 7'h0;
    @(negedge clk);
    test_reset();
    test_static();
    test_brightness();
    test_scroll();
    test_blink();
    test_write_hazard();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 The block SHALL have parameter DIGITS, default 8, giving the number of multiplexed digits (1..BUF_DEPTH).
REQ-002 The block SHALL have parameter SCAN_DIV, default 10_000, giving the clk cycles per digit slot (minimum 8).
REQ-003 The block SHALL have parameter BUF_DEPTH, default 16, giving the number of segment-pattern buffer entries (power of two, at least DIGITS).
REQ-004 The block SHALL have parameter SCROLL_DIV, default 50, giving the full frames per scroll step and per blink phase (minimum 1).
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port wr_en, input, width 1: buffer write strobe.
REQ-008 The block SHALL have port wr_addr, input, width clog2(BUF_DEPTH): buffer write address.
REQ-009 The block SHALL have port wr_seg, input, width 7: segment pattern to write.
REQ-010 The block SHALL have port mode, input, width 2: 00 static, 01 scroll, 10 blink, 11 blank.
REQ-011 The block SHALL have port brightness, input, width 3: duty level, where 7 is full on.
REQ-012 The block SHALL have port seg, output, width 7: registered segment drive.
REQ-013 The block SHALL have port digit_select, output, width DIGITS: registered one-hot digit enable.
REQ-014 The block SHALL have port frame_done, output, width 1: one-cycle pulse at the end of each frame.

Function
REQ-015 The scan counter SHALL count from 0 to SCAN_DIV-1 and wrap; the cycle with count SCAN_DIV-1 is the tick.
REQ-016 On each tick, the digit index SHALL advance and wrap from DIGITS-1 to 0.
REQ-017 frame_done SHALL be asserted for exactly one cycle, on the cycle after a tick with digit index DIGITS-1.
REQ-018 The mode register SHALL load mode only on a frame boundary (tick with index DIGITS-1); a mid-frame change of mode SHALL have no effect until then.
REQ-019 When the slot is lit, digit_select SHALL be one-hot of the digit index and seg SHALL equal buf[(offset+index) mod BUF_DEPTH], both registered one cycle after the index/counter update.
REQ-020 A slot is lit only when scan count < ((brightness+1)*SCAN_DIV)/8; otherwise seg and digit_select SHALL both be 0.
REQ-021 In scroll mode, a frame counter SHALL count frames and, on reaching SCROLL_DIV, reset and increment offset mod BUF_DEPTH, so that the offset wraps from BUF_DEPTH-1 to 0.
REQ-022 In static, blink and blank modes, offset SHALL be 0; the offset SHALL clear at the frame boundary where the mode register leaves scroll.
REQ-023 In blink mode, a phase bit SHALL toggle every SCROLL_DIV frames, starting lit; while the phase is off, outputs SHALL be 0.
REQ-024 In blank mode, seg and digit_select SHALL be 0; the scan counter and frame_done SHALL keep running.
REQ-025 When wr_en is high, buf[wr_addr] SHALL take wr_seg at the clock edge; a read of the same entry in that cycle returns the old value, and the new value appears from the next cycle.
REQ-026 The buffer SHALL accept writes in every mode and at any time, with no stall.

Reset
REQ-027 On rst high at a clk edge, the scan counter, digit index, frame counter, offset, blink phase and mode register (static) SHALL all clear to 0.
REQ-028 On reset, all buffer entries, seg, digit_select and frame_done SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse, and scanning SHALL restart at digit 0 on the first cycle after rst deasserts.

Structure
REQ-030 Shared package seg_pkg SHALL hold the mode encodings (MODE_STATIC, MODE_SCROLL, MODE_BLINK, MODE_BLANK) and the constant SEG_BLANK = 7'b0.
REQ-031 The scan counter, digit index and frame_done generation SHALL form sub-module seg_scan_timer, parameterised by DIGITS and SCAN_DIV.

Verification (DIGITS=4, SCAN_DIV=8, BUF_DEPTH=8, SCROLL_DIV=2)
REQ-032 Static mode: write buf[0..3] = 7'h3F, 06, 5B, 4F, brightness 7 -> digit_select runs 0001, 0010, 0100, 1000 for 8 cycles each with matching seg, and frame_done pulses every 32 cycles.
REQ-033 Brightness 3 -> each slot lit for scan counts 0..3 and dark (seg=0, digit_select=0) for counts 4..7.
REQ-034 Scroll mode with buf[i] = i+1 -> offset steps every 64 cycles; digit 0 shows 1, 2, ..., 8, then 1 again (wrap at 7 back to 0).
REQ-035 Blink mode -> 2 frames lit, 2 frames all zero, repeating; a mode change mid-frame is ignored until the next frame_done.
REQ-036 Write buf[2] = 7'h7F during digit 2's lit slot -> the new pattern appears on seg the following cycle.
REQ-037 Reset pulsed at scan count 5 of digit 2 -> all outputs 0 and buffer cleared; after release, digit 0 is selected with seg = 0.
